// File: rtl/axi_read_arbiter.sv
// rtl/axi_read_arbiter.sv - round-robin arbiter sharing one AXI4 read port among NUM_REQ requesters
module axi_read_arbiter #(
  parameter int NUM_REQ         = 2,
  parameter int IDX_W           = 1,
  parameter int MAX_OUTSTANDING = 4,
  parameter int ID_W            = 6
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [NUM_REQ*32-1:0]  req_addr,
  input  logic [NUM_REQ*8-1:0]   req_len,
  output logic [NUM_REQ-1:0]     rsp_valid,
  input  logic [NUM_REQ-1:0]     rsp_ready,
  output logic [31:0]            rsp_data,
  output logic                   rsp_last,
  output logic [31:0]            axi_araddr,
  output logic [7:0]             axi_arlen,
  output logic [2:0]             axi_arsize,
  output logic [1:0]             axi_arburst,
  output logic [ID_W-1:0]        axi_arid,
  output logic                   axi_arvalid,
  input  logic                   axi_arready,
  input  logic [31:0]            axi_rdata,
  input  logic [ID_W-1:0]        axi_rid,
  input  logic                   axi_rlast,
  input  logic                   axi_rvalid,
  output logic                   axi_rready
);

  localparam int CNT_W = 4;

  typedef enum logic {ST_IDLE, ST_ISSUE} ar_state_e;

  ar_state_e          state_q, state_d;
  logic [31:0]        araddr_q, araddr_d;
  logic [7:0]         arlen_q, arlen_d;
  logic [IDX_W-1:0]   arid_q, arid_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;
  logic [CNT_W-1:0]   count_q [NUM_REQ];
  logic [CNT_W-1:0]   count_d [NUM_REQ];

  logic [NUM_REQ-1:0] eligible;
  logic               ar_free;
  logic               grant;
  logic [IDX_W-1:0]   win_idx;
  logic [IDX_W-1:0]   rid_idx;
  logic               rid_ok;
  logic               r_last_hs;

  assign rid_idx   = axi_rid[IDX_W-1:0];
  assign rid_ok    = {{(32-IDX_W){1'b0}}, rid_idx} < 32'(NUM_REQ);
  assign r_last_hs = axi_rvalid && axi_rready && axi_rlast && rid_ok;

  // R path is pure routing; ids outside the requester range are sunk so the bus never stalls
  always_comb begin
    rsp_valid = '0;
    if (axi_rvalid && rid_ok) rsp_valid[rid_idx] = 1'b1;
    axi_rready = rid_ok ? rsp_ready[rid_idx] : 1'b1;
    rsp_data   = axi_rdata;
    rsp_last   = axi_rlast;
  end

  always_comb begin
    for (int k = 0; k < NUM_REQ; k++) begin
      eligible[k] = req_valid[k] && (count_q[k] < CNT_W'(MAX_OUTSTANDING));
    end
  end

  // Round-robin search starting at the pointer; first eligible requester wins
  always_comb begin
    int cand;
    cand    = 0;
    grant   = 1'b0;
    win_idx = '0;
    ar_free = (state_q == ST_IDLE) || axi_arready;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = int'(ptr_q) + i;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (!grant && eligible[cand[IDX_W-1:0]]) begin
        grant   = 1'b1;
        win_idx = cand[IDX_W-1:0];
      end
    end
    if (rst || !ar_free) grant = 1'b0;
    req_ready = '0;
    if (grant) req_ready[win_idx] = 1'b1;
  end

  always_comb begin
    state_d  = state_q;
    araddr_d = araddr_q;
    arlen_d  = arlen_q;
    arid_d   = arid_q;
    ptr_d    = ptr_q;
    if (grant) begin
      state_d  = ST_ISSUE;
      araddr_d = req_addr[win_idx*32 +: 32];
      arlen_d  = req_len[win_idx*8 +: 8];
      arid_d   = win_idx;
      ptr_d    = (32'(win_idx) == 32'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
    end else if (state_q == ST_ISSUE && axi_arready) begin
      state_d = ST_IDLE;
    end
  end

  // A grant and a returning rlast for the same requester cancel out
  always_comb begin
    for (int k = 0; k < NUM_REQ; k++) begin
      count_d[k] = count_q[k];
      if (grant && win_idx == IDX_W'(k)) begin
        if (!(r_last_hs && rid_idx == IDX_W'(k))) count_d[k] = count_q[k] + 1'b1;
      end else if (r_last_hs && rid_idx == IDX_W'(k) && count_q[k] != '0) begin
        count_d[k] = count_q[k] - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      araddr_q <= '0;
      arlen_q  <= '0;
      arid_q   <= '0;
      ptr_q    <= '0;
      for (int k = 0; k < NUM_REQ; k++) count_q[k] <= '0;
    end else begin
      state_q  <= state_d;
      araddr_q <= araddr_d;
      arlen_q  <= arlen_d;
      arid_q   <= arid_d;
      ptr_q    <= ptr_d;
      for (int k = 0; k < NUM_REQ; k++) count_q[k] <= count_d[k];
    end
  end

  assign axi_arvalid = (state_q == ST_ISSUE);
  assign axi_araddr  = araddr_q;
  assign axi_arlen   = arlen_q;
  assign axi_arid    = ID_W'(arid_q);
  assign axi_arsize  = 3'b010;
  assign axi_arburst = 2'b01;

  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (!(r_last_hs && count_q[rid_idx] == '0))
        else $error("rlast for requester with no outstanding burst");
      assert (!(axi_rvalid && !rid_ok))
        else $error("R beat with out-of-range id dropped");
    end
  end

  if (ID_W > IDX_W) begin : g_rid_upper
    always_ff @(posedge clk) begin
      if (!rst) begin
        assert (!(axi_rvalid && axi_rid[ID_W-1:IDX_W] != '0))
          else $error("R beat with nonzero upper id bits");
      end
    end
  end

endmodule

// File: tb/tb_axi_read_arbiter.sv
// tb/tb_axi_read_arbiter.sv - randomized bench for axi_read_arbiter against a transaction-level model
module tb_axi_read_arbiter;

  localparam int NR   = 2;
  localparam int IDXW = 1;
  localparam int MAXO = 4;
  localparam int IDW  = 6;

  logic              clk = 1'b0;
  logic              rst;
  logic [NR-1:0]     req_valid, req_ready, rsp_valid, rsp_ready;
  logic [NR*32-1:0]  req_addr;
  logic [NR*8-1:0]   req_len;
  logic [31:0]       rsp_data, axi_araddr, axi_rdata;
  logic              rsp_last, axi_arvalid, axi_arready, axi_rlast, axi_rvalid, axi_rready;
  logic [7:0]        axi_arlen;
  logic [2:0]        axi_arsize;
  logic [1:0]        axi_arburst;
  logic [IDW-1:0]    axi_arid, axi_rid;

  axi_read_arbiter #(.NUM_REQ(NR), .IDX_W(IDXW), .MAX_OUTSTANDING(MAXO), .ID_W(IDW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_len(req_len),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_last(rsp_last),
    .axi_araddr(axi_araddr), .axi_arlen(axi_arlen), .axi_arsize(axi_arsize),
    .axi_arburst(axi_arburst), .axi_arid(axi_arid), .axi_arvalid(axi_arvalid),
    .axi_arready(axi_arready), .axi_rdata(axi_rdata), .axi_rid(axi_rid),
    .axi_rlast(axi_rlast), .axi_rvalid(axi_rvalid), .axi_rready(axi_rready)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          id;
    logic [31:0] addr;
    int          len;
    int          beat;
  } burst_t;

  burst_t      bq[$];
  int          vec_cnt = 0;
  int          err_cnt = 0;

  int          m_cnt[NR];
  int          m_ptr;
  bit          m_arv;
  logic [31:0] m_addr;
  logic [7:0]  m_len;
  int          m_id;

  bit          r_hold;
  int          r_cur;
  bit          r_en;
  int          req_pct;
  int          ardy_pct;
  int          grants_seen[NR];

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < NR; k++) m_cnt[k] = 0;
    m_ptr  = 0;
    m_arv  = 0;
    m_addr = '0;
    m_len  = '0;
    m_id   = 0;
    r_hold = 0;
    bq.delete();
  endtask

  task automatic drive();
    for (int k = 0; k < NR; k++) begin
      req_valid[k]         = ($urandom_range(0, 99) < req_pct);
      req_addr[k*32 +: 32] = $urandom() & 32'hFFFF_FFFC;
      req_len[k*8 +: 8]    = 8'($urandom_range(0, 7));
      rsp_ready[k]         = ($urandom_range(0, 3) != 0);
    end
    axi_arready = ($urandom_range(0, 99) < ardy_pct);
    if (rst) begin
      r_hold     = 0;
      axi_rvalid = 1'b0;
      axi_rlast  = 1'b0;
      axi_rid    = '0;
    end else if (!r_hold) begin
      axi_rvalid = 1'b0;
      axi_rlast  = 1'b0;
      axi_rid    = '0;
      axi_rdata  = $urandom();
      if (r_en && bq.size() > 0 && $urandom_range(0, 3) != 0) begin
        int  want;
        bit  found;
        want  = $urandom_range(0, NR - 1);
        found = 0;
        r_cur = 0;
        for (int j = 0; j < bq.size(); j++) begin
          if (!found && bq[j].id == want) begin
            found = 1;
            r_cur = j;
          end
        end
        axi_rvalid = 1'b1;
        axi_rid    = IDW'(bq[r_cur].id);
        axi_rdata  = bq[r_cur].addr + 32'(bq[r_cur].beat * 4);
        axi_rlast  = (bq[r_cur].beat == bq[r_cur].len);
      end
    end
  endtask

  task automatic check_update();
    bit            free;
    bit            g;
    int            win;
    int            c;
    int            rid;
    logic [NR-1:0] exp_rr;
    logic [NR-1:0] exp_rv;
    logic          exp_rdy;

    check_val("arvalid", 64'(axi_arvalid), 64'(m_arv));
    check_val("araddr", 64'(axi_araddr), 64'(m_addr));
    check_val("arlen", 64'(axi_arlen), 64'(m_len));
    check_val("arid", 64'(axi_arid), 64'(m_id));
    check_val("arsize", 64'(axi_arsize), 64'(3'b010));
    check_val("arburst", 64'(axi_arburst), 64'(2'b01));

    free = !m_arv || axi_arready;
    g    = 0;
    win  = 0;
    if (!rst && free) begin
      for (int i = 0; i < NR; i++) begin
        c = (m_ptr + i) % NR;
        if (!g && req_valid[c] && m_cnt[c] < MAXO) begin
          g   = 1;
          win = c;
        end
      end
    end
    exp_rr = g ? (NR'(1) << win) : '0;
    check_val("req_ready", 64'(req_ready), 64'(exp_rr));

    rid     = int'(axi_rid[IDXW-1:0]);
    exp_rv  = axi_rvalid ? (NR'(1) << rid) : '0;
    exp_rdy = rsp_ready[rid];
    check_val("rsp_valid", 64'(rsp_valid), 64'(exp_rv));
    check_val("axi_rready", 64'(axi_rready), 64'(exp_rdy));
    if (axi_rvalid) begin
      check_val("rsp_data", 64'(rsp_data), 64'(axi_rdata));
      check_val("rsp_last", 64'(rsp_last), 64'(axi_rlast));
    end

    if (rst) begin
      model_reset();
      return;
    end

    if (m_arv && axi_arready)
      bq.push_back('{id: m_id, addr: m_addr, len: int'(m_len), beat: 0});
    if (g) begin
      m_arv  = 1;
      m_addr = req_addr[win*32 +: 32];
      m_len  = req_len[win*8 +: 8];
      m_id   = win;
      m_cnt[win]++;
      grants_seen[win]++;
      m_ptr  = (win + 1) % NR;
    end else if (m_arv && axi_arready) begin
      m_arv = 0;
    end

    if (axi_rvalid) begin
      if (exp_rdy) begin
        burst_t b;
        b = bq[r_cur];
        if (b.beat == b.len) begin
          bq.delete(r_cur);
          m_cnt[b.id]--;
        end else begin
          b.beat++;
          bq[r_cur] = b;
        end
        r_hold = 0;
      end else begin
        r_hold = 1;
      end
    end
  endtask

  task automatic run(input int n, input bit do_rst);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      rst = do_rst;
      drive();
      @(negedge clk);
      check_update();
    end
  endtask

  initial begin
    rst         = 1'b1;
    req_valid   = '0;
    req_addr    = '0;
    req_len     = '0;
    rsp_ready   = '0;
    axi_arready = 1'b0;
    axi_rvalid  = 1'b0;
    axi_rdata   = '0;
    axi_rid     = '0;
    axi_rlast   = 1'b0;
    r_cur       = 0;
    for (int k = 0; k < NR; k++) grants_seen[k] = 0;
    model_reset();

    r_en = 0; req_pct = 50; ardy_pct = 70;
    run(3, 1'b1);
    r_en = 1;
    run(1200, 1'b0);
    // back-pressure on AR: registers must hold while arvalid waits
    ardy_pct = 0;
    run(12, 1'b0);
    // saturate every requester with no R traffic so the outstanding limit bites
    r_en = 0; req_pct = 100; ardy_pct = 100;
    run(40, 1'b0);
    r_en = 1; ardy_pct = 30; req_pct = 60;
    run(500, 1'b0);
    run(3, 1'b1);
    ardy_pct = 60; req_pct = 40;
    run(1500, 1'b0);
    req_pct = 0; ardy_pct = 100;
    run(400, 1'b0);
    check_val("drained", 64'(bq.size()), 64'd0);
    for (int k = 0; k < NR; k++) begin
      vec_cnt++;
      if (grants_seen[k] == 0) begin
        err_cnt++;
        $display("FAIL grants_req%0d got=0 exp=nonzero", k);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
